// File: rtl/cacheline_burst_responder_if.sv
// Cache line request/response and physical memory burst signals for cacheline_burst_responder.
// master: the cache plus memory side; slave: the responder.
interface cacheline_burst_responder_if #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
);
    logic              line_read;
    logic              line_write;
    logic [31:0]       line_addr;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;

    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        output line_read, line_write, line_addr, line_wdata, mem_rdata, mem_resp,
        input  line_rdata, line_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  line_read, line_write, line_addr, line_wdata, mem_rdata, mem_resp,
        output line_rdata, line_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cacheline_burst_responder.sv
// Turns single 256-bit line reads/writes into 4-beat 64-bit memory bursts; all outputs registered.
// Optional last-read line buffer enabled by defining CACHELINE_LAST_READ_BUF_EN.
module cacheline_burst_responder #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned BEAT_W    = 64
) (
    input logic                       clk,
    input logic                       rst_n,
    cacheline_burst_responder_if.slave bus
);
    localparam int unsigned LineW = BURST_LEN * BEAT_W;
    localparam int unsigned CntW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned OffW  = $clog2(LineW / 8);
    localparam int unsigned TagW  = 32 - OffW;
    localparam logic [31:0] AddrMask = ~((32'd1 << OffW) - 32'd1);
    localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRdBurst,
        StWrBurst,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   beat_cnt_q;
    logic [CntW-1:0]   beat_nxt;
    logic [LineW-1:0]  wdata_q;
    logic [LineW-1:0]  line_rdata_q;
    logic              line_resp_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_addr_q;
    logic [BEAT_W-1:0] mem_wdata_q;
`ifdef CACHELINE_LAST_READ_BUF_EN
    logic              valid_q;
    logic [TagW-1:0]   tag_q;
`endif

    assign beat_nxt = beat_cnt_q + CntW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            beat_cnt_q   <= '0;
            wdata_q      <= '0;
            line_rdata_q <= '0;
            line_resp_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef CACHELINE_LAST_READ_BUF_EN
            valid_q      <= 1'b0;
            tag_q        <= '0;
`endif
        end else begin
            line_resp_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Write has priority; a concurrent read is dropped, not queued.
                    if (bus.line_write) begin
                        state_q     <= StWrBurst;
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= bus.line_addr & AddrMask;
                        wdata_q     <= bus.line_wdata;
                        mem_wdata_q <= bus.line_wdata[BEAT_W-1:0];
                        beat_cnt_q  <= '0;
`ifdef CACHELINE_LAST_READ_BUF_EN
                        if (bus.line_addr[31:OffW] == tag_q) begin
                            valid_q <= 1'b0;
                        end
`endif
                    end else if (bus.line_read) begin
                        mem_addr_q <= bus.line_addr & AddrMask;
                        beat_cnt_q <= '0;
`ifdef CACHELINE_LAST_READ_BUF_EN
                        if (valid_q && (bus.line_addr[31:OffW] == tag_q)) begin
                            state_q     <= StDone;
                            line_resp_q <= 1'b1;
                        end else
`endif
                        begin
                            state_q    <= StRdBurst;
                            mem_read_q <= 1'b1;
                        end
                    end
                end

                StRdBurst: begin
                    if (bus.mem_resp) begin
                        line_rdata_q[int'(beat_cnt_q) * BEAT_W +: BEAT_W] <= bus.mem_rdata;
                        beat_cnt_q <= beat_nxt;
                        if (beat_cnt_q == LastBeat) begin
                            beat_cnt_q  <= '0;
                            state_q     <= StDone;
                            mem_read_q  <= 1'b0;
                            line_resp_q <= 1'b1;
`ifdef CACHELINE_LAST_READ_BUF_EN
                            valid_q     <= 1'b1;
                            tag_q       <= mem_addr_q[31:OffW];
`endif
                        end
                    end
                end

                StWrBurst: begin
                    // mem_wdata presents the next beat only once the current one is accepted.
                    if (bus.mem_resp) begin
                        beat_cnt_q  <= beat_nxt;
                        mem_wdata_q <= wdata_q[int'(beat_nxt) * BEAT_W +: BEAT_W];
                        if (beat_cnt_q == LastBeat) begin
                            beat_cnt_q  <= '0;
                            state_q     <= StDone;
                            mem_write_q <= 1'b0;
                            line_resp_q <= 1'b1;
                        end
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.line_rdata = line_rdata_q;
    assign bus.line_resp  = line_resp_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_cacheline_burst_responder.sv
// Directed bench for cacheline_burst_responder: reads, writes with waits, priority, reset abort,
// and (when CACHELINE_LAST_READ_BUF_EN is defined) last-read buffer hits.
module tb_cacheline_burst_responder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cacheline_burst_responder_if bus ();

    cacheline_burst_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait read of addr; memory returns the beats of line, lowest beat first.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [255:0] line);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFE0;
        bus.line_read = 1'b1;
        bus.line_addr = addr;
        step();
        bus.line_read = 1'b0;
        bus.line_addr = 32'hFFFF_FFFF;
        chk({tag, " c1 mem_read"}, 256'(bus.mem_read), 256'd1);
        chk({tag, " c1 mem_addr"}, 256'(bus.mem_addr), 256'(base));
        for (int i = 0; i < 4; i++) begin
            chk({tag, " no early resp"}, 256'(bus.line_resp), 256'd0);
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = line[i*64 +: 64];
            step();
        end
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 64'h0;
        chk({tag, " c5 line_resp"}, 256'(bus.line_resp), 256'd1);
        chk({tag, " c5 mem_read"}, 256'(bus.mem_read), 256'd0);
        chk({tag, " c5 line_rdata"}, bus.line_rdata, line);
        step();
        chk({tag, " c6 line_resp"}, 256'(bus.line_resp), 256'd0);
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] wline;
    logic [255:0] wline2;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.line_addr  = 32'h0;
        bus.line_wdata = '0;
        bus.mem_rdata  = 64'h0;
        bus.mem_resp   = 1'b0;
        line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        line_b = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                  64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        wline  = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                  64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
        wline2 = {64'hE3E3_0000_0000_0003, 64'hE2E2_0000_0000_0002,
                  64'hE1E1_0000_0000_0001, 64'hE0E0_0000_0000_0000};

        step();
        step();
        rst_n = 1'b1;
        chk("rst line_resp", 256'(bus.line_resp), 256'd0);
        chk("rst line_rdata", bus.line_rdata, 256'd0);
        chk("rst mem_read", 256'(bus.mem_read), 256'd0);
        chk("rst mem_write", 256'(bus.mem_write), 256'd0);
        chk("rst mem_addr", 256'(bus.mem_addr), 256'd0);
        chk("rst mem_wdata", 256'(bus.mem_wdata), 256'd0);

        // mem_resp in IDLE must not start anything.
        bus.mem_resp = 1'b1;
        step();
        bus.mem_resp = 1'b0;
        chk("idle mem_resp ignored", 256'({bus.mem_read, bus.mem_write, bus.line_resp}), 256'd0);

        do_read("read0", 32'h0000_1234, line_a);

        // Write with mem_resp every other cycle; line_resp lands in cycle 9.
        bus.line_write = 1'b1;
        bus.line_addr  = 32'h0000_5A1F;
        bus.line_wdata = wline;
        step();
        bus.line_write = 1'b0;
        bus.line_wdata = '0;
        chk("wr mem_addr", 256'(bus.mem_addr), 256'h0000_5A00);
        for (int i = 0; i < 4; i++) begin
            chk("wr mem_write", 256'(bus.mem_write), 256'd1);
            chk("wr wait wdata", 256'(bus.mem_wdata), 256'(wline[i*64 +: 64]));
            chk("wr wait resp", 256'(bus.line_resp), 256'd0);
            step();
            bus.mem_resp = 1'b1;
            chk("wr held wdata", 256'(bus.mem_wdata), 256'(wline[i*64 +: 64]));
            step();
            bus.mem_resp = 1'b0;
        end
        chk("wr c9 line_resp", 256'(bus.line_resp), 256'd1);
        chk("wr c9 mem_write", 256'(bus.mem_write), 256'd0);
        chk("wr keeps line_rdata", bus.line_rdata, line_a);
        step();
        chk("wr c10 line_resp", 256'(bus.line_resp), 256'd0);

        // Read and write together: write wins, read dropped.
        bus.line_read  = 1'b1;
        bus.line_write = 1'b1;
        bus.line_addr  = 32'h0000_3000;
        bus.line_wdata = wline2;
        step();
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("both mem_write", 256'(bus.mem_write), 256'd1);
            chk("both mem_read", 256'(bus.mem_read), 256'd0);
            chk("both wdata", 256'(bus.mem_wdata), 256'(wline2[i*64 +: 64]));
            bus.mem_resp = 1'b1;
            step();
        end
        bus.mem_resp = 1'b0;
        chk("both line_resp", 256'(bus.line_resp), 256'd1);
        chk("both line_rdata", bus.line_rdata, line_a);
        step();
        chk("both single resp", 256'(bus.line_resp), 256'd0);
        chk("both no read", 256'(bus.mem_read), 256'd0);

        // Reset in the middle of a read burst (during beat 2).
        bus.line_read = 1'b1;
        bus.line_addr = 32'h0000_2040;
        step();
        bus.line_read = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        bus.mem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
        step();
        rst_n = 1'b0;
        bus.mem_rdata = 64'hCCCC_CCCC_CCCC_CCCC;
        step();
        rst_n = 1'b1;
        bus.mem_resp = 1'b0;
        chk("abort mem_read", 256'(bus.mem_read), 256'd0);
        chk("abort line_rdata", bus.line_rdata, 256'd0);
        chk("abort line_resp", 256'(bus.line_resp), 256'd0);
        step();
        chk("abort no late resp", 256'(bus.line_resp), 256'd0);
        chk("abort idle", 256'(bus.mem_read), 256'd0);
        do_read("fresh", 32'h0000_2040, line_b);

        do_read("read1220", 32'h0000_1220, line_a);

        // Repeat read of the same line.
        bus.line_read = 1'b1;
        bus.line_addr = 32'h0000_1220;
        step();
        bus.line_read = 1'b0;
`ifdef CACHELINE_LAST_READ_BUF_EN
        chk("hit mem_read", 256'(bus.mem_read), 256'd0);
        chk("hit c1 line_resp", 256'(bus.line_resp), 256'd1);
        chk("hit line_rdata", bus.line_rdata, line_a);
        step();
        chk("hit c2 line_resp", 256'(bus.line_resp), 256'd0);
        chk("hit c2 mem_read", 256'(bus.mem_read), 256'd0);

        // A write to the buffered line invalidates it.
        bus.line_write = 1'b1;
        bus.line_wdata = wline;
        step();
        bus.line_write = 1'b0;
        bus.mem_resp   = 1'b1;
        for (int i = 0; i < 4; i++) step();
        bus.mem_resp = 1'b0;
        chk("inv wr resp", 256'(bus.line_resp), 256'd1);
        step();
        do_read("after inv", 32'h0000_1220, line_b);
`else
        chk("repeat c1 mem_read", 256'(bus.mem_read), 256'd1);
        chk("repeat c1 line_resp", 256'(bus.line_resp), 256'd0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = line_b[i*64 +: 64];
            step();
        end
        bus.mem_resp = 1'b0;
        chk("repeat c5 line_resp", 256'(bus.line_resp), 256'd1);
        chk("repeat line_rdata", bus.line_rdata, line_b);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
